// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/response handshake, hands
// instructions to decode. Define FETCH_SEQ_MISALIGN_CHK_EN to halt on misaligned next-PC targets.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        imem_rsp_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        trap_en,
    input  logic [31:0] trap_vec,
    input  logic        jalr_en,
    input  logic [31:0] jalr_tgt,
    input  logic        jal_en,
    input  logic        br_en,
    input  logic [31:0] offset,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] inst_cnt
);

    typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_inst, r_inst_pc, r_cnt;
    logic        r_mis;
    logic        w_consume;
    logic [31:0] w_tgt, w_npc;
    logic        w_mis;

    assign w_consume = (r_state == S_HOLD) && inst_ready;

    // Only the highest-priority asserted redirect contributes to the target.
    always_comb begin
        w_tgt = r_pc + 32'd4;
        if (trap_en)
            w_tgt = trap_vec;
        else if (jalr_en)
            w_tgt = jalr_tgt & ~32'd1;
        else if (jal_en || br_en)
            w_tgt = r_inst_pc + (offset << 1);
    end

`ifdef FETCH_SEQ_MISALIGN_CHK_EN
    assign w_mis = |w_tgt[1:0];
    assign w_npc = w_tgt;
`else
    assign w_mis = 1'b0;
    assign w_npc = w_tgt & ~32'd3;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_BOOT;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT: w_next = S_REQ;
            S_REQ:  if (imem_req_ready) w_next = S_WAIT;
            S_WAIT: if (imem_rsp_valid) w_next = S_HOLD;
            S_HOLD: if (inst_ready) w_next = (halt_req || w_mis) ? S_HALT : S_REQ;
            S_HALT: w_next = S_HALT;
            default: w_next = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        imem_rsp_ready = 1'b0;
        inst_valid     = 1'b0;
        halted         = 1'b0;
        case (r_state)
            S_REQ:  imem_req_valid = 1'b1;
            S_WAIT: imem_rsp_ready = 1'b1;
            S_HOLD: inst_valid     = 1'b1;
            S_HALT: halted         = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_cnt     <= '0;
            r_mis     <= 1'b0;
        end else begin
            if (r_state == S_WAIT && imem_rsp_valid) begin
                r_inst    <= imem_rsp_data;
                r_inst_pc <= r_pc;
            end
            // Halt outranks every redirect; a misaligned target halts with pc left as is.
            if (w_consume) begin
                r_cnt <= r_cnt + 32'd1;
                if (!halt_req) begin
                    if (w_mis)
                        r_mis <= 1'b1;
                    else
                        r_pc  <= w_npc;
                end
            end
        end
    end

    assign imem_req_addr = r_pc;
    assign pc            = r_pc;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign inst_cnt      = r_cnt;
    assign misalign_err  = r_mis;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed redirect table, multi-cycle handshake/reset sequences and
// randomized traffic against an architectural next-PC model.
module tb_fetch_seq;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        trap_en, jalr_en, jal_en, br_en, halt_req;
    logic [31:0] trap_vec, jalr_tgt, offset;
    logic [31:0] pc, inst_cnt;
    logic        halted, misalign_err;

    fetch_seq dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_ready(imem_rsp_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .trap_en(trap_en), .trap_vec(trap_vec), .jalr_en(jalr_en), .jalr_tgt(jalr_tgt),
        .jal_en(jal_en), .br_en(br_en), .offset(offset), .halt_req(halt_req),
        .pc(pc), .halted(halted), .misalign_err(misalign_err), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory behaviour knobs
    int rdy_delay = 0, rsp_delay = 0, req_w = 0, rsp_w = 0;
    bit noise = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // Drives the memory side for one cycle from the currently visible state, then advances.
    task automatic cycle();
        if (imem_req_valid) begin
            imem_req_ready = (req_w >= rdy_delay);
            req_w++;
        end else begin
            imem_req_ready = noise ? 1'($urandom) : 1'b0;
            req_w = 0;
        end
        if (imem_rsp_ready) begin
            imem_rsp_valid = (rsp_w >= rsp_delay);
            imem_rsp_data  = memf(imem_req_addr);
            rsp_w++;
        end else begin
            imem_rsp_valid = noise ? 1'($urandom) : 1'b0;
            imem_rsp_data  = $urandom;
            rsp_w = 0;
        end
        @(negedge clk);
    endtask

    task automatic clear_redirects();
        trap_en = 0; jalr_en = 0; jal_en = 0; br_en = 0; halt_req = 0;
        trap_vec = 0; jalr_tgt = 0; offset = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inst_ready = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        clear_redirects();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
        cycle();
        chk("first_req", {31'd0, imem_req_valid}, 32'd1);
        chk("first_addr", imem_req_addr, RPC);
    endtask

    task automatic wait_hold();
        for (int i = 0; i < 64; i++) begin
            if (inst_valid) return;
            cycle();
        end
        chk("hold_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume(input logic tr, input logic [31:0] tv, input logic jr,
                           input logic [31:0] jt, input logic jl, input logic br,
                           input logic [31:0] off, input logic hl);
        trap_en = tr; trap_vec = tv; jalr_en = jr; jalr_tgt = jt;
        jal_en = jl; br_en = br; offset = off; halt_req = hl;
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        clear_redirects();
    endtask

    // Architectural next-PC rule: returns {misaligned, target}.
    function automatic logic [32:0] model_next(input logic [31:0] ipc, input logic tr,
        input logic [31:0] tv, input logic jr, input logic [31:0] jt, input logic jl,
        input logic br, input logic [31:0] off);
        logic [31:0] t;
        if (tr)            t = tv;
        else if (jr)       t = {jt[31:1], 1'b0};
        else if (jl || br) t = ipc + off * 2;
        else               t = ipc + 4;
`ifdef FETCH_SEQ_MISALIGN_CHK_EN
        return {(t % 4) != 0, t};
`else
        return {1'b0, t - (t % 4)};
`endif
    endfunction

    typedef struct {
        logic [31:0] start;
        logic        tr;
        logic [31:0] tv;
        logic        jr;
        logic [31:0] jt;
        logic        jl, br;
        logic [31:0] off;
        logic        hl;
        logic [31:0] exp_pc;
        logic        exp_halt, exp_mis;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] req_addr[3];
        int          req_cyc[3];
        int          n_req, n_con;
        logic        prev;
        logic [31:0] hold_inst, hold_ipc, m_pc, m_cnt;
        logic        m_halt, m_mis;
        logic [32:0] nx;

        vecs[0] = '{32'h8000_0010, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h8000_0000, 0, 0};
        vecs[1] = '{32'h8000_0010, 1, 32'h8000_1000, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h8000_1000, 0, 0};
        vecs[3] = '{32'h8000_0020, 0, 0, 0, 0, 0, 1, 32'h0000_0010, 0, 32'h8000_0040, 0, 0};
        vecs[4] = '{32'h8000_0010, 0, 0, 0, 0, 1, 0, 32'h0000_0100, 1, 32'h8000_0010, 1, 0};
        vecs[5] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0000, 0, 0};
        vecs[6] = '{32'h8000_0000, 0, 0, 0, 0, 0, 1, 32'h4000_0000, 0, 32'h0000_0000, 0, 0};
        vecs[7] = '{32'h8000_0040, 0, 0, 1, 32'h1234_5679, 0, 0, 32'h0, 0, 32'h1234_5678, 0, 0};
`ifdef FETCH_SEQ_MISALIGN_CHK_EN
        vecs[2] = '{32'h8000_0010, 0, 0, 1, 32'h8000_0103, 0, 0, 32'h0, 0, 32'h8000_0010, 1, 1};
        vecs[8] = '{32'h8000_0000, 0, 0, 0, 0, 1, 0, 32'h0000_0001, 0, 32'h8000_0000, 1, 1};
        vecs[9] = '{32'h8000_0100, 1, 32'h0000_0007, 0, 0, 0, 0, 32'h0, 0, 32'h8000_0100, 1, 1};
`else
        vecs[2] = '{32'h8000_0010, 0, 0, 1, 32'h8000_0103, 0, 0, 32'h0, 0, 32'h8000_0100, 0, 0};
        vecs[8] = '{32'h8000_0000, 0, 0, 0, 0, 1, 0, 32'h0000_0001, 0, 32'h8000_0000, 0, 0};
        vecs[9] = '{32'h8000_0100, 1, 32'h0000_0007, 0, 0, 0, 0, 32'h0, 0, 32'h0000_0004, 0, 0};
`endif

        // reset values
        rst = 1'b1;
        inst_ready = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        clear_redirects();
        @(negedge clk);
        chk("rst_pc", pc, RPC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_cnt", inst_cnt, 32'd0);
        chk("rst_valids", {28'd0, imem_req_valid, imem_rsp_ready, inst_valid, halted}, 32'd0);
        chk("rst_mis", {31'd0, misalign_err}, 32'd0);

        // sequential zero-wait fetch
        do_reset();
        n_req = 0; n_con = 0; prev = 0;
        inst_ready = 1'b1;
        for (int c = 0; c < 40 && n_con < 3; c++) begin
            if (imem_req_valid && !prev) begin
                if (n_req < 3) begin
                    req_addr[n_req] = imem_req_addr;
                    req_cyc[n_req]  = c;
                end
                n_req++;
            end
            prev = imem_req_valid;
            if (inst_valid) n_con++;
            cycle();
        end
        inst_ready = 1'b0;
        chk("seq_nreq", n_req, 3);
        chk("seq_a0", req_addr[0], 32'h8000_0000);
        chk("seq_a1", req_addr[1], 32'h8000_0004);
        chk("seq_a2", req_addr[2], 32'h8000_0008);
        chk("seq_gap1", req_cyc[1] - req_cyc[0], 3);
        chk("seq_gap2", req_cyc[2] - req_cyc[1], 3);
        chk("seq_cnt", inst_cnt, 32'd3);

        // redirect table
        for (int v = 0; v < 10; v++) begin
            do_reset();
            wait_hold();
            consume(1, vecs[v].start, 0, 0, 0, 0, 0, 0);
            wait_hold();
            chk($sformatf("v%0d_ipc", v), inst_pc, vecs[v].start);
            consume(vecs[v].tr, vecs[v].tv, vecs[v].jr, vecs[v].jt,
                    vecs[v].jl, vecs[v].br, vecs[v].off, vecs[v].hl);
            chk($sformatf("v%0d_pc", v), pc, vecs[v].exp_pc);
            chk($sformatf("v%0d_halt", v), {31'd0, halted}, {31'd0, vecs[v].exp_halt});
            chk($sformatf("v%0d_mis", v), {31'd0, misalign_err}, {31'd0, vecs[v].exp_mis});
            chk($sformatf("v%0d_req", v), {31'd0, imem_req_valid}, {31'd0, ~vecs[v].exp_halt});
            chk($sformatf("v%0d_cnt", v), inst_cnt, 32'd2);
        end

        // stalled memory and stalled decode
        do_reset();
        rdy_delay = 5; rsp_delay = 4;
        n_req = 0; n_con = 0;
        for (int c = 0; c < 40 && !inst_valid; c++) begin
            if (imem_req_valid) begin
                n_req++;
                chk("stall_addr", imem_req_addr, RPC);
            end
            if (imem_rsp_ready) n_con++;
            cycle();
        end
        chk("stall_req_cycles", n_req, 6);
        chk("stall_wait_cycles", n_con, 5);
        chk("stall_inst", inst, memf(RPC));
        hold_inst = inst; hold_ipc = inst_pc;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("stall_hold_v", {31'd0, inst_valid}, 32'd1);
            chk("stall_hold_inst", inst, hold_inst);
            chk("stall_hold_ipc", inst_pc, hold_ipc);
        end
        consume(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_cnt", inst_cnt, 32'd1);
        rdy_delay = 0; rsp_delay = 0;

        // halt beats jal; no further fetch
        do_reset();
        wait_hold();
        consume(0, 0, 0, 0, 1, 0, 32'h0000_0040, 1);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, RPC);
        n_req = 0;
        for (int c = 0; c < 20; c++) begin
            if (imem_req_valid) n_req++;
            inst_ready = 1'($urandom);
            cycle();
        end
        inst_ready = 0;
        chk("halt_no_req", n_req, 0);
        chk("halt_cnt", inst_cnt, 32'd1);
        chk("halt_stays", {31'd0, halted}, 32'd1);

        // reset while waiting on a response
        do_reset();
        wait_hold();
        consume(1, 32'h8000_0200, 0, 0, 0, 0, 0, 0);
        rsp_delay = 3;
        for (int c = 0; c < 10 && !imem_rsp_ready; c++) cycle();
        cycle();
        chk("rw_in_wait", {31'd0, imem_rsp_ready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_async_rdy", {31'd0, imem_rsp_ready}, 32'd0);
        chk("rw_async_pc", pc, RPC);
        chk("rw_async_cnt", inst_cnt, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        chk("rw_rsp_drop_v", {31'd0, inst_valid}, 32'd0);
        chk("rw_rsp_drop_i", inst, 32'd0);
        rst = 1'b0;
        chk("rw_boot", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        chk("rw_req", {31'd0, imem_req_valid}, 32'd1);
        chk("rw_inst_v", {31'd0, inst_valid}, 32'd0);
        chk("rw_addr", imem_req_addr, RPC);
        chk("rw_cnt", inst_cnt, 32'd0);
        rsp_delay = 0;

        // randomized traffic against the architectural model
        do_reset();
        noise = 1;
        m_pc = RPC; m_cnt = 0; m_halt = 0; m_mis = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) begin
                rdy_delay = $urandom_range(0, 3);
                rsp_delay = $urandom_range(0, 3);
            end
            if (imem_req_valid) chk("rnd_addr", imem_req_addr, m_pc);
            if (inst_valid) begin
                chk("rnd_inst", inst, memf(m_pc));
                chk("rnd_ipc", inst_pc, m_pc);
            end
            inst_ready = ($urandom % 3) != 0;
            trap_en  = ($urandom % 8) == 0;
            jalr_en  = ($urandom % 6) == 0;
            jal_en   = ($urandom % 5) == 0;
            br_en    = ($urandom % 4) == 0;
            halt_req = ($urandom % 40) == 0;
            trap_vec = $urandom;
            if ($urandom % 4 != 0) trap_vec[1:0] = 2'b00;
            jalr_tgt = $urandom;
            if ($urandom % 4 != 0) jalr_tgt[1] = 1'b0;
            offset   = 32'($urandom_range(0, 127)) - 32'd64;
            if ($urandom % 4 != 0) offset[0] = 1'b0;
            if (inst_valid && inst_ready) begin
                m_cnt = m_cnt + 1;
                nx = model_next(m_pc, trap_en, trap_vec, jalr_en, jalr_tgt, jal_en, br_en, offset);
                if (halt_req) m_halt = 1;
                else if (nx[32]) begin m_halt = 1; m_mis = 1; end
                else m_pc = nx[31:0];
            end
            cycle();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_cnt", inst_cnt, m_cnt);
            chk("rnd_halt", {31'd0, halted}, {31'd0, m_halt});
            chk("rnd_mis", {31'd0, misalign_err}, {31'd0, m_mis});
            if (m_halt) begin
                cycle();
                chk("rnd_halt_noreq", {31'd0, imem_req_valid}, 32'd0);
                do_reset();
                m_pc = RPC; m_cnt = 0; m_halt = 0; m_mis = 0;
            end
        end
        noise = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer for the NPC core. Owns the program counter and drives the instruction-memory request/response handshake. Presents each fetched instruction to decode with a valid/ready handshake. On each accepted instruction, it selects the next PC from the trap, jump, branch and sequential sources, and it halts the core on ebreak.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset; the first fetch address.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction word.
- imem_rsp_ready  out  1  sequencer accepts a response.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  registered instruction word.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode/execute consumes inst this cycle.
- trap_en  in  1  take trap; target trap_vec.
- trap_vec  in  32  trap vector address.
- jalr_en  in  1  register-indirect jump; target jalr_tgt & ~1.
- jalr_tgt  in  32  jalr computed address.
- jal_en  in  1  direct jump; target inst_pc + (offset << 1).
- br_en  in  1  taken branch; target inst_pc + (offset << 1).
- offset  in  32  sign-extended immediate in halfword units.
- halt_req  in  1  ebreak retired.
- pc  out  32  current fetch PC.
- halted  out  1  sequencer is in HALT.
- misalign_err  out  1  sticky flag: a misaligned target was detected.
- inst_cnt  out  32  count of consumed instructions.

## Operation
- States:
  - BOOT: reset state.
  - REQ: imem_req_valid=1.
  - WAIT: imem_rsp_ready=1.
  - HOLD: inst_valid=1.
  - HALT: absorbing.
- Transitions:
  - BOOT→REQ unconditionally.
  - REQ→WAIT when imem_req_ready=1.
  - WAIT→HOLD when imem_rsp_valid=1; inst←imem_rsp_data, inst_pc←pc in that same edge.
  - HOLD→REQ on a consume, i.e. inst_valid & inst_ready.
  - HOLD→HALT on a consume with halt_req=1.
  - HALT persists until rst.
- Redirect inputs and halt_req are sampled only on a consume. At all other times they are don't-care.
- Next-PC priority on a consume: trap_en > jalr_en > jal_en > br_en > pc+4. Only the highest-priority asserted source is used.
- halt_req has priority over all redirects. On halt, pc holds its value and no further fetch is issued.
- All PC arithmetic is modulo 2^32 and wraps silently. offset<<1 keeps 32 bits.
- inst_cnt increments by 1 per consume, including the halting instruction, and wraps at 2^32.
- imem_rsp_valid outside WAIT is ignored. imem_req_ready outside REQ is ignored.
- Reset mid-operation, in any state:
  - immediately state=BOOT, pc=RESET_PC, outputs deasserted;
  - any in-flight response is dropped;
  - inst_cnt=0, misalign_err=0.

## Timing
- Reset values:
  - pc=RESET_PC, inst=0, inst_pc=0, inst_cnt=0;
  - all valid/ready outputs 0, halted=0, misalign_err=0.
- Handshake outputs are decoded combinationally from the state register only; no input-to-output paths.
- imem_req_addr is stable while imem_req_valid=1.
- Minimum fetch-to-fetch cost is 3 cycles (REQ, WAIT, HOLD), with zero-wait memory and inst_ready=1.
- First request after reset release: imem_req_valid rises 1 cycle after the first posedge (the BOOT cycle).
- A response arrives no earlier than the cycle after request acceptance. inst_valid rises the cycle after imem_rsp_valid.
- inst and inst_pc are stable while inst_valid=1.

## Configuration
- FETCH_SEQ_MISALIGN_CHK_EN defined:
  - a selected next PC with bits [1:0] != 0 sets misalign_err=1 and enters HALT instead of REQ;
  - pc is not updated.
- Undefined:
  - next PC bits [1:0] are forced to 0;
  - misalign_err is tied to 0.

## Test plan
- Reset then zero-wait memory, inst_ready=1, no redirects → imem_req_addr sequence 0x80000000, 0x80000004, 0x80000008, one fetch every 3 cycles; inst_cnt=3 after third consume.
- Consume at inst_pc=0x80000010 with jal_en=1, br_en=1, offset=0xFFFFFFF8 → next pc 0x80000000 (jal wins, shared target); with trap_en=1 also asserted → pc=trap_vec=0x80001000.
- jalr_en=1, jalr_tgt=0x80000103 → with macro defined: HALT, misalign_err=1, pc unchanged; without macro: pc=0x80000100.
- imem_req_ready held 0 for 5 cycles, then rsp delayed 4 cycles; inst_ready held 0 for 3 cycles → address, inst and inst_pc stable throughout; exactly one consume counted.
- Consume with halt_req=1 and jal_en=1 → halted=1, imem_req_valid stays 0 for 20 cycles, inst_cnt incremented once.
- Assert rst while in WAIT, then deliver imem_rsp_valid during reset → response ignored; after release pc=0x80000000, inst_cnt=0, first request issued after the BOOT cycle.
